// File: rtl/bios_ioctl_loader.sv
`default_nettype none
// ============================================================================
// Module   : bios_ioctl_loader
// Purpose  : Streams a BIOS image from an ioctl download port into SRAM one
//            byte at a time. The loader checks the image as it goes (length,
//            address range, protocol) and keeps a running 8-bit checksum.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_28_636      in   1  sole clock, rising edge
//   reset_n         in   1  synchronous active-low reset
//   ioctl_download  in   1  download window active
//   ioctl_wr        in   1  one-cycle byte strobe
//   ioctl_addr      in  25  byte offset within the image
//   ioctl_dout      in   8  byte data
//   ioctl_index     in   8  image selector
//   ioctl_wait      out  1  stall request to the ioctl source (registered)
//   mem_addr        out 21  SRAM write address
//   mem_dout        out  8  SRAM write data
//   mem_we          out  1  write request, held until mem_ack
//   mem_ack         in   1  write-accepted strobe from the SRAM arbiter
//   bios_loaded     out  1  a complete, valid image is present
//   load_error      out  1  the last BIOS download was invalid
//   checksum        out  8  modulo-256 sum of the bytes written
// ============================================================================
module bios_ioctl_loader #(
  parameter logic [7:0]  BIOS_INDEX = 8'h00,
  parameter logic [20:0] BIOS_BASE  = 21'h0F0000,
  parameter logic [16:0] BIOS_SIZE  = 17'h10000
) (
  input  logic        clk_28_636,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  output logic [20:0] mem_addr,
  output logic [7:0]  mem_dout,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        bios_loaded,
  output logic        load_error,
  output logic [7:0]  checksum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [24:0] C_SIZE_EXT = {8'd0, BIOS_SIZE};

  state_t      state_q;
  logic        wait_q;
  logic        we_q;
  logic [20:0] addr_q;     // holding register: target address
  logic [7:0]  data_q;     // holding register: byte to write
  logic        loaded_q;
  logic        err_q;
  logic [7:0]  cks_q;
  logic [16:0] count_q;

  logic        in_range_d;
  logic [20:0] mem_addr_d;
  logic [16:0] count_d;

  // Addresses beyond the image never reach SRAM.
  assign in_range_d = (ioctl_addr < C_SIZE_EXT);
  // 21-bit sum: wraps around the SRAM space by design.
  assign mem_addr_d = BIOS_BASE + ioctl_addr[20:0];
  // Byte counter saturates rather than wrapping back to a plausible size.
  assign count_d    = (count_q == '1) ? count_q : count_q + 17'd1;

  always_ff @(posedge clk_28_636) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      wait_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
      cks_q    <= '0;
      count_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          wait_q <= 1'b0;
          we_q   <= 1'b0;
          // Other indices are not ours: status from the last BIOS load stays.
          if (ioctl_download && (ioctl_index == BIOS_INDEX)) begin
            state_q  <= S_LOAD;
            cks_q    <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            loaded_q <= 1'b0;
          end
        end

        S_LOAD: begin
          // wait is only ever a single-cycle pulse here (out-of-range byte).
          wait_q <= 1'b0;
          if (!ioctl_download) begin
            state_q <= S_DONE;
          end else if (ioctl_wr) begin
            if (wait_q) begin
              // Strobe while stalled: the source ignored ioctl_wait.
              err_q <= 1'b1;
            end else if (in_range_d) begin
              addr_q  <= mem_addr_d;
              data_q  <= ioctl_dout;
              we_q    <= 1'b1;
              wait_q  <= 1'b1;
              state_q <= S_WRITE;
            end else begin
              wait_q <= 1'b1;
              err_q  <= 1'b1;
            end
          end
        end

        S_WRITE: begin
          if (ioctl_wr) begin
            err_q <= 1'b1;
          end
          // A falling download still waits here for the ack; LOAD then
          // notices the closed window and moves on to DONE.
          if (mem_ack) begin
            we_q    <= 1'b0;
            wait_q  <= 1'b0;
            cks_q   <= cks_q + data_q;
            count_q <= count_d;
            state_q <= S_LOAD;
          end
        end

        S_DONE: begin
          wait_q <= 1'b0;
          we_q   <= 1'b0;
          if ((count_q == BIOS_SIZE) && !err_q) begin
            loaded_q <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ioctl_wait  = wait_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_dout    = data_q;
  assign bios_loaded = loaded_q;
  assign load_error  = err_q;
  assign checksum    = cks_q;

endmodule
`default_nettype wire

// File: tb/tb_bios_ioctl_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_bios_ioctl_loader
// Purpose  : Directed bench for bios_ioctl_loader with a 16-byte image.
//            Expected SRAM writes go into a scoreboard queue when a byte is
//            issued; a monitor pops them when mem_we rises and checks that
//            address/data hold steady until the write is acknowledged.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bios_ioctl_loader;

  logic        clk;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        ioctl_wait;
  logic [20:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        mem_we;
  logic        mem_ack;
  logic        bios_loaded;
  logic        load_error;
  logic [7:0]  checksum;

  int n_chk;
  int n_err;

  // SRAM responder controls
  logic ack_resp;
  logic stray_ack;
  logic ack_en;
  int   ack_delay;
  int   ack_cnt;

  // Scoreboard: {addr[20:0], data[7:0]}
  logic [28:0] exp_q[$];
  logic [28:0] exp_w;
  logic        prev_we;
  logic [20:0] held_a;
  logic [7:0]  held_d;

  assign mem_ack = ack_resp | stray_ack;

  bios_ioctl_loader #(
    .BIOS_INDEX(8'h00),
    .BIOS_BASE (21'h0F0000),
    .BIOS_SIZE (17'd16)
  ) dut (
    .clk_28_636    (clk),
    .reset_n       (reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_index   (ioctl_index),
    .ioctl_wait    (ioctl_wait),
    .mem_addr      (mem_addr),
    .mem_dout      (mem_dout),
    .mem_we        (mem_we),
    .mem_ack       (mem_ack),
    .bios_loaded   (bios_loaded),
    .load_error    (load_error),
    .checksum      (checksum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Acknowledges ack_delay cycles after mem_we is first seen (0 = same cycle).
  initial begin
    ack_resp = 1'b0;
    ack_cnt  = 0;
    forever begin
      @(negedge clk);
      if (!reset_n || !ack_en) begin
        ack_resp = 1'b0;
        ack_cnt  = 0;
      end else if (ack_resp) begin
        ack_resp = 1'b0;
        ack_cnt  = 0;
      end else if (mem_we) begin
        if (ack_cnt == ack_delay) ack_resp = 1'b1;
        else ack_cnt++;
      end
    end
  end

  // Monitor: pops one expected write per mem_we rise, checks stability after.
  initial begin
    prev_we = 1'b0;
    held_a  = '0;
    held_d  = '0;
    forever begin
      @(negedge clk);
      if (mem_we && !prev_we) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_we: got write addr=0x%0h data=0x%0h, required no write",
                   mem_addr, mem_dout);
        end else begin
          exp_w = exp_q.pop_front();
          if ({mem_addr, mem_dout} !== exp_w) begin
            n_err++;
            $display("FAIL sb_write: got addr=0x%0h data=0x%0h, required addr=0x%0h data=0x%0h",
                     mem_addr, mem_dout, exp_w[28:8], exp_w[7:0]);
          end
        end
        held_a = mem_addr;
        held_d = mem_dout;
      end else if (mem_we && prev_we) begin
        n_chk++;
        if (mem_addr !== held_a || mem_dout !== held_d) begin
          n_err++;
          $display("FAIL we_stable: got addr=0x%0h data=0x%0h, required addr=0x%0h data=0x%0h",
                   mem_addr, mem_dout, held_a, held_d);
        end
      end
      prev_we = mem_we;
    end
  end

  // Called at a negedge; returns at a negedge with ioctl_wait low.
  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    int k;
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    @(negedge clk);
    ioctl_wr = 1'b0;
    k = 0;
    while (ioctl_wait && k < 50) begin
      k++;
      @(negedge clk);
    end
    chk("wr_byte_wait_release", (k < 50) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic end_download();
    ioctl_download = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int k;
    n_chk = 0;
    n_err = 0;
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    ioctl_index    = 8'h00;
    stray_ack      = 1'b0;
    ack_en         = 1'b1;
    ack_delay      = 2;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst_wait", {31'd0, ioctl_wait}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", {11'd0, mem_addr}, 32'd0);
    chk("rst_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst_loaded", {31'd0, bios_loaded}, 32'd0);
    chk("rst_err", {31'd0, load_error}, 32'd0);
    chk("rst_cks", {24'd0, checksum}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // ---- full load: 16 x 0x01, ack two cycles late ----
    ioctl_download = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({21'h0F0000 + 21'(i), 8'h01});
      wr_byte(25'(i), 8'h01);
    end
    end_download();
    chk("full_loaded", {31'd0, bios_loaded}, 32'd1);
    chk("full_err", {31'd0, load_error}, 32'd0);
    chk("full_cks", {24'd0, checksum}, 32'h10);

    // ---- other index: ignored, status persists ----
    ioctl_index    = 8'h01;
    ioctl_download = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = 8'hC3;
      @(negedge clk);
      ioctl_wr = 1'b0;
      chk("other_idx_wait", {31'd0, ioctl_wait}, 32'd0);
      @(negedge clk);
    end
    end_download();
    chk("other_idx_loaded", {31'd0, bios_loaded}, 32'd1);
    chk("other_idx_err", {31'd0, load_error}, 32'd0);
    chk("other_idx_cks", {24'd0, checksum}, 32'h10);

    // ---- short load: 15 bytes of i*0x11, immediate ack ----
    ioctl_index    = 8'h00;
    ack_delay      = 0;
    ioctl_download = 1'b1;
    @(negedge clk);
    chk("entry_clr_loaded", {31'd0, bios_loaded}, 32'd0);
    chk("entry_clr_cks", {24'd0, checksum}, 32'd0);
    exp_q.push_back({21'h0F0000, 8'h00});
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'd0;
    ioctl_dout = 8'h00;
    @(negedge clk);
    ioctl_wr = 1'b0;
    chk("b2b_wait_on", {31'd0, ioctl_wait}, 32'd1);
    @(negedge clk);
    chk("b2b_wait_off", {31'd0, ioctl_wait}, 32'd0);
    for (int i = 1; i < 15; i++) begin
      exp_q.push_back({21'h0F0000 + 21'(i), 8'(i * 17)});
      wr_byte(25'(i), 8'(i * 17));
    end
    end_download();
    chk("short_loaded", {31'd0, bios_loaded}, 32'd0);
    chk("short_err", {31'd0, load_error}, 32'd1);
    chk("short_cks", {24'd0, checksum}, 32'hF9);

    // ---- out of range: addr 16 ----
    ioctl_download = 1'b1;
    @(negedge clk);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'd16;
    ioctl_dout = 8'hAA;
    @(negedge clk);
    ioctl_wr = 1'b0;
    chk("oor_wait_on", {31'd0, ioctl_wait}, 32'd1);
    chk("oor_no_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    chk("oor_wait_off", {31'd0, ioctl_wait}, 32'd0);
    end_download();
    chk("oor_err", {31'd0, load_error}, 32'd1);
    chk("oor_loaded", {31'd0, bios_loaded}, 32'd0);
    chk("oor_cks", {24'd0, checksum}, 32'd0);

    // ---- backpressure: ack held off 10 cycles, extra strobe in the stall ----
    ack_delay      = 10;
    ioctl_download = 1'b1;
    @(negedge clk);
    exp_q.push_back({21'h0F0003, 8'h5A});
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'd3;
    ioctl_dout = 8'h5A;
    @(negedge clk);
    ioctl_wr = 1'b0;
    chk("bp_err_before", {31'd0, load_error}, 32'd0);
    k = 0;
    while (ioctl_wait && k < 40) begin
      k++;
      if (k == 3) begin
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'd4;
        ioctl_dout = 8'h77;
      end else begin
        ioctl_wr = 1'b0;
      end
      @(negedge clk);
    end
    ioctl_wr = 1'b0;
    chk("bp_wait_cycles", 32'(k), 32'd11);
    chk("bp_err", {31'd0, load_error}, 32'd1);
    end_download();
    chk("bp_cks", {24'd0, checksum}, 32'h5A);
    chk("bp_loaded", {31'd0, bios_loaded}, 32'd0);

    // ---- reset while a write is pending ----
    ack_en         = 1'b0;
    ioctl_download = 1'b1;
    @(negedge clk);
    exp_q.push_back({21'h0F0005, 8'h33});
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'd5;
    ioctl_dout = 8'h33;
    @(negedge clk);
    ioctl_wr = 1'b0;
    chk("rw_we_pending", {31'd0, mem_we}, 32'd1);
    reset_n     = 1'b0;
    ioctl_index = 8'h01;
    @(negedge clk);
    chk("rw_wait", {31'd0, ioctl_wait}, 32'd0);
    chk("rw_we", {31'd0, mem_we}, 32'd0);
    chk("rw_addr", {11'd0, mem_addr}, 32'd0);
    chk("rw_dout", {24'd0, mem_dout}, 32'd0);
    chk("rw_loaded", {31'd0, bios_loaded}, 32'd0);
    chk("rw_err", {31'd0, load_error}, 32'd0);
    chk("rw_cks", {24'd0, checksum}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    chk("rw_stray_we", {31'd0, mem_we}, 32'd0);
    chk("rw_stray_cks", {24'd0, checksum}, 32'd0);
    // Download still high but with a foreign index: strobes are ignored.
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'd0;
    ioctl_dout = 8'h55;
    @(negedge clk);
    ioctl_wr = 1'b0;
    chk("rw_reentry_wait", {31'd0, ioctl_wait}, 32'd0);
    @(negedge clk);
    ioctl_download = 1'b0;
    ioctl_index    = 8'h00;
    repeat (3) @(negedge clk);
    chk("rw_final_err", {31'd0, load_error}, 32'd0);
    chk("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
